// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: store-strobe bytes are queued in a FIFO and
// serialized LSB first. Writes into a full FIFO are dropped and flagged.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int CW           = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_overflow,
    output logic          tx,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    logic [7:0]      mem [DEPTH];

    logic            full_int;
    logic            empty_int;
    logic            push;
    logic            pop;
    logic            drop;
    logic            bit_end;

    // full/empty come from the registered count, so a pop never frees space for a same-cycle write
    assign full_int  = (count_q == FULL_COUNT);
    assign empty_int = (count_q == '0);
    assign push      = wr_en && !full_int;
    assign drop      = wr_en && full_int;
    assign pop       = (state_q == IDLE) && !empty_int;
    assign bit_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end

        // tx/busy are computed one cycle ahead so the line itself comes straight off a flop
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (pop) begin
                    shift_d = mem[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wr_data;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign empty    = empty_int;
    assign full     = full_int;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter that consumes the byte stream the CPU produces with stores to the UART MMIO address.
- The memory stage pulses a byte-write strobe each time it executes such a store. This block queues the bytes in a FIFO and serializes them 8N1 on a single output line.
- The single-cycle core never stalls. When the FIFO is full, writes are dropped and a sticky overflow flag is raised for software to poll.

Parameters:
DEPTH, 16, FIFO entries; power of 2, min 2
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); min 2
CW, $clog2(DEPTH)+1, width of the count output (derived; do not override)

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-high
wr_en  input  1  byte write strobe from memory stage, one byte per cycle high
wr_data  input  8  byte to queue
clr_overflow  input  1  clears sticky overflow flag
tx  output  1  serial line, idle high
busy  output  1  serializer mid-frame (START..STOP)
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  CW  FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset (rst_n high, async, takes effect immediately, including mid-frame):
  - tx=1, busy=0, empty=1, full=0, count=0, overflow=0.
  - Read and write pointers cleared; FIFO contents discarded.
  - FSM returns to IDLE; baud counter and bit index cleared.
- All outputs are registered or decoded from registered count. empty=(count==0), full=(count==DEPTH).
- Push: on wr_en && !full, write wr_data at wptr. wptr wraps modulo DEPTH.
- Drop: on wr_en && full, the byte is discarded and overflow is set.
  - full is sampled from the registered count. A write while full is dropped even if a pop happens in the same cycle.
- Overflow flag: clr_overflow clears it. If a drop and clr_overflow occur in the same cycle, set wins.
- Pop: happens only in IDLE when !empty. The byte at rptr is loaded into the shift register and rptr wraps modulo DEPTH.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on push and pop together. Never exceeds DEPTH and never underflows.
- FSM states:
  - IDLE: tx=1, busy=0. If !empty: pop, reload the baud counter, go to START next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - busy=1 in START, DATA and STOP.
- Baud counter: counts 0..CLKS_PER_BIT-1. A bit period ends when the count equals CLKS_PER_BIT-1; the counter then resets to 0.
- Latency: wr_en at cycle N into an empty FIFO with the FSM in IDLE:
  - count=1 at N+1.
  - Pop at N+1.
  - tx falls at N+2.
  - Frame occupies N+2 .. N+2+10*CLKS_PER_BIT-1.
- Back-to-back frames: exactly one IDLE cycle (tx=1) between the end of STOP and the next START.
- wr_en while the FSM is busy only queues the byte. It never disturbs the frame in flight.

Test Plan:
Use DEPTH=4, CLKS_PER_BIT=4 unless stated.

1. Single byte: reset, then wr_en with 0xA5 at cycle N.
   - tx=0 during N+2..N+5.
   - Data bits 1,0,1,0,0,1,0,1, each held 4 cycles.
   - Stop bit high during N+38..N+41; busy falls at N+42; count returns to 0 by N+2.
2. Fill and overflow: write 0x10..0x15 on consecutive cycles N..N+5.
   - count sequence 1,1,2,3,4; full=1 at N+5.
   - 0x15 dropped; overflow=1 at N+6.
   - Line carries 0x10..0x14 in order, each frame separated by exactly one idle-high cycle.
3. Overflow clear priority: with full=1, assert wr_en and clr_overflow in the same cycle → overflow=1. A lone clr_overflow on the next cycle → overflow=0.
4. Pointer wrap: across 3 batches of 3 bytes each (9 bytes total), drain fully after every batch.
   - All 9 bytes are received intact and in order.
   - empty=1 at the end.
5. Reset mid-frame: assert rst_n during DATA bit 3 of 0x5A with 2 bytes queued.
   - tx=1 and busy=0 asynchronously; count=0.
   - After release, no further frames are transmitted.
6. Simultaneous push and pop: write a byte in the same cycle IDLE pops the only entry → count stays 1, and the second frame starts one cycle after the first STOP ends.
